pipe_stage_hs: RTL and testbench

//   Parametrised pipeline stage register with valid/ready handshake, flush and
//   NOP-bubble insertion for the RV32I pipeline (IF/ID, ID/EX, ...). Supersedes

---
 rtl/pipe_stage_hs_pkg.sv | 7 +
 rtl/pipe_stage_hs_if.sv | 13 +
 rtl/pipe_stage_hs_entry.sv | 38 +++
 rtl/pipe_stage_hs.sv | 90 +++++++++
 tb/tb_pipe_stage_hs.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared RV32I pipeline constants used by the pipeline stage registers.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // ADDI x0,x0,0

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready payload bus. The master drives data/valid, and the slave drives ready.
interface pipe_stage_hs_if #(
  parameter int unsigned BitWidth = riscv_pkg::XLEN
) ();

  logic [BitWidth-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pipe_stage_hs_entry.sv
// Single pipeline entry: a payload flop and a valid flop.
// The payload reads NopValue whenever the entry is empty.
module pipe_skid_entry
  import riscv_pkg::*;
#(
  parameter int unsigned         BitWidth = XLEN,
  parameter logic [BitWidth-1:0] NopValue = BitWidth'(RV_NOP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [BitWidth-1:0] i_data,
  output logic [BitWidth-1:0] o_data,
  output logic                o_valid
);

  logic [BitWidth-1:0] r_data;
  logic                r_valid;

  // Clear wins over load, so a flush always leaves a NOP behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= NopValue;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_data  <= NopValue;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with a valid/ready handshake, flush, and NOP bubbles.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_hs
  import riscv_pkg::*;
#(
  parameter int unsigned         BitWidth = XLEN,
  parameter logic [BitWidth-1:0] NopValue = BitWidth'(RV_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_hs_if.slave    in_if,
  pipe_stage_hs_if.master   out_if
);

  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_main_load;
  logic                w_main_clear;
  logic                w_main_valid;
  logic [BitWidth-1:0] w_main_din;
  logic [BitWidth-1:0] w_main_data;

  assign w_in_fire = in_if.valid && w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic                r_in_ready;
  logic                w_drain;
  logic                w_skid_load;
  logic                w_skid_clear;
  logic                w_skid_valid;
  logic [BitWidth-1:0] w_skid_data;

  // Main refills from skid first, which keeps order. in_ready is low while skid is full.
  assign w_in_ready   = r_in_ready;
  assign w_drain      = !w_main_valid || out_if.ready;
  assign w_main_load  = !flush && w_drain && (w_skid_valid || w_in_fire);
  assign w_main_clear = flush || (w_drain && !w_skid_valid && !w_in_fire);
  assign w_main_din   = w_skid_valid ? w_skid_data : in_if.data;
  assign w_skid_load  = !flush && !w_drain && w_in_fire;
  assign w_skid_clear = flush || (w_drain && w_skid_valid);

  pipe_skid_entry #(
    .BitWidth (BitWidth),
    .NopValue (NopValue)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_if.data),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= !(w_skid_load || (w_skid_valid && !w_skid_clear));
    end
  end
`else
  logic w_out_fire;

  assign w_out_fire   = w_main_valid && out_if.ready;
  assign w_in_ready   = rst && (out_if.ready || !w_main_valid);
  assign w_main_load  = !flush && w_in_fire;
  assign w_main_clear = flush || (w_out_fire && !w_in_fire);
  assign w_main_din   = in_if.data;
`endif

  pipe_skid_entry #(
    .BitWidth (BitWidth),
    .NopValue (NopValue)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_data  (w_main_data),
    .o_valid (w_main_valid)
  );

  assign in_if.ready  = w_in_ready;
  assign out_if.data  = w_main_data;
  assign out_if.valid = w_main_valid;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs. It runs directed tables, then random traffic against a
// queue model of the stage.
module tb_pipe_stage_hs;
  import riscv_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned Cap = 2;
`else
  localparam int unsigned Cap = 1;
`endif
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  pipe_stage_hs_if #(.BitWidth(32)) u_in ();
  pipe_stage_hs_if #(.BitWidth(32)) u_out ();

  pipe_stage_hs #(
    .BitWidth (32),
    .NopValue (32'h0000_0013)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (u_in),
    .out_if (u_out)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        eir;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    u_in.valid  = v;
    u_in.data   = d;
    u_out.ready = ordy;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [31:0] ed, input logic eir);
    chk({name, ".out_valid"}, 32'(u_out.valid), 32'(ev));
    chk({name, ".out_data"},  u_out.data, ed);
    chk({name, ".in_ready"},  32'(u_in.ready), 32'(eir));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_ir;
    logic        v, ordy, fl;
    logic [31:0] d;

    // Reset held while upstream presents a valid beat
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, Nop, 1'b0);
    u_in.valid = 1'b0;
    rst = 1'b1;
    step();
    chk_out("release", 1'b0, Nop, 1'b1);

`ifndef PIPE_STAGE_SKID_EN
    tbl.push_back('{1'b1, 32'h0000_0093, 1'b1, 1'b0, 1'b1, 32'h0000_0093, 1'b1});
    tbl.push_back('{1'b1, 32'h0010_0113, 1'b1, 1'b0, 1'b1, 32'h0010_0113, 1'b1});
    tbl.push_back('{1'b1, 32'h0020_0193, 1'b1, 1'b0, 1'b1, 32'h0020_0193, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, Nop,           1'b1});
    tbl.push_back('{1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0});
    tbl.push_back('{1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0});
    tbl.push_back('{1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0});
    tbl.push_back('{1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0});
    tbl.push_back('{1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0, Nop,           1'b1});
    tbl.push_back('{1'b1, 32'hCCCC_0003, 1'b1, 1'b1, 1'b0, Nop,           1'b1});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, Nop,           1'b1});
    tbl.push_back('{1'b1, 32'hDDDD_0004, 1'b0, 1'b0, 1'b1, 32'hDDDD_0004, 1'b0});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, Nop,           1'b1});
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eir);
    end
`else
    // Backpressure: A goes to main, B to skid, and C is held upstream until room frees
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0); step(); chk_out("bp_a",   1'b1, 32'hAAAA_0001, 1'b1);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0); step(); chk_out("bp_b",   1'b1, 32'hAAAA_0001, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0); step(); chk_out("bp_c",   1'b1, 32'hAAAA_0001, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 1'b1, 1'b0); step(); chk_out("bp_outb", 1'b1, 32'hBBBB_0002, 1'b1);
    drive(1'b1, 32'hCCCC_0003, 1'b1, 1'b0); step(); chk_out("bp_outc", 1'b1, 32'hCCCC_0003, 1'b1);
    drive(1'b0, 32'h0,         1'b1, 1'b0); step(); chk_out("bp_empty", 1'b0, Nop, 1'b1);
    // Flush while both entries are full
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0); step();
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0); step(); chk_out("fl_full", 1'b1, 32'hAAAA_0001, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b1); step(); chk_out("fl_kill", 1'b0, Nop, 1'b1);
    drive(1'b0, 32'h0,         1'b1, 1'b0); step(); chk_out("fl_after", 1'b0, Nop, 1'b1);
`endif

    // Async reset between clock edges, with no edge allowed before the check
    drive(1'b1, 32'h5555_0005, 1'b0, 1'b0); step();
    chk_out("pre_arst", 1'b1, 32'h5555_0005, Cap == 2 ? 1'b1 : 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk_out("arst", 1'b0, Nop, 1'b0);
    @(negedge clk) rst = 1'b1;
    step();
    drive(1'b1, 32'h7777_0007, 1'b1, 1'b0); step(); chk_out("restart", 1'b1, 32'h7777_0007, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step(); step();

    // Random traffic checked against a FIFO of capacity Cap
    q.delete();
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      d    = $urandom;
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      drive(v, d, ordy, fl);
      #1;
      exp_ir = (Cap == 1) ? (q.size() == 0 || ordy) : (q.size() < 2);
      chk("rnd.out_valid", 32'(u_out.valid), 32'(q.size() != 0));
      chk("rnd.out_data", u_out.data, (q.size() != 0) ? q[0] : Nop);
      chk("rnd.in_ready", 32'(u_in.ready), 32'(exp_ir));
      @(posedge clk);
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (v && exp_ir) q.push_back(d);
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
